act_pingpong_buf: RTL and testbench
===================================

# act_pingpong_buf

Dual-bank activation buffer sitting directly downstream of `controlengine`: it consumes `rd_step`, `source_addr`, `dest_addr` and `wren` and turns them into actual activation reads and layer-result writes. One bank serves reads for the current layer while the other collects the layer's results. The banks swap roles whenever the engine advances `rd_step`. A host port loads the input vector and reads back the final layer.

## Interface
- `Ba`, 8, activation word width; also the width of the step buses.
- `Bm`, 6, address width; each bank holds 2^Bm words.
- `LAT`, 2, datapath latency in cycles from `wren` issue to `wr_data` arrival; legal range ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rd_step`  in  Ba  layer step from the engine; a change in value triggers a bank swap.
- `wr_step`  in  Ba  accepted and unused; reserved.
- `source_addr`  in  Bm  read address into the read bank.
- `dest_addr`  in  Bm  write address, captured when `wren` is issued.
- `wren`  in  1  issues a delayed write to `dest_addr`.
- `wr_data`  in  Ba  result word, sampled LAT cycles after its `wren`.
- `host_we`  in  1  host write into the read bank.
- `host_addr`  in  Bm  host address, used for both read and write.
- `host_wdata`  in  Ba  host write data.
- `rd_data`  out  Ba  registered read data for `source_addr`.
- `host_rdata`  out  Ba  registered read-bank data for `host_addr`.
- `bank_sel`  out  1  selects the read bank: 0 means bank0 is read and bank1 is written; 1 means the reverse.
- `pending`  out  1  high while any delayed write is in flight.

## Operation
- Reset (`rst` = 0):
  - Outputs: `rd_data`, `host_rdata`, `bank_sel` and `pending` all go to 0.
  - Internal state: `step_q` goes to 0 and every delay-line valid bit is cleared.
  - Memory contents are not reset.
- Swap detection:
  - `step_q` registers `rd_step` every cycle.
  - If `rd_step != step_q` in a cycle, `bank_sel` toggles at the end of that cycle.
  - Reads issued during that cycle still use the old `bank_sel`.
  - A held `rd_step` never retriggers a swap.
- Write issue:
  - When `wren` = 1, the entry {valid, target bank = `~bank_sel` at issue, `dest_addr`} enters a LAT-deep delay line.
  - The target bank is frozen at issue time, so a swap never redirects an in-flight write.
- Write commit: when an entry exits the delay line, `wr_data` of that cycle is written to {target bank, addr}. This holds even if that bank has since become the read bank.
- Read port: `rd_data` is loaded with read-bank[`source_addr`] every cycle. There is no enable.
- Forwarding: a commit to the same bank and address as a same-cycle read (port `source_addr` or `host_addr`) returns the new `wr_data`.
- Host port:
  - `host_we` writes `host_wdata` into the read bank.
  - `host_rdata` returns read-bank[`host_addr`].
  - On a same-edge collision between a host write and a datapath commit at the same bank and address, the datapath write wins and the host write is dropped.
- `pending` is the OR of all delay-line valid bits.
- Reset mid-operation: all in-flight writes are discarded and never commit.

## Timing
- `source_addr` / `host_addr` presented in cycle t → `rd_data` / `host_rdata` valid in cycle t+1.
- `wren` in cycle t:
  - `wr_data` is sampled in cycle t+LAT.
  - Memory is updated at the edge ending cycle t+LAT.
  - `pending` is high in cycles t+1 through t+LAT.
- Back-to-back `wren` sustains one write per cycle with no stall.
- `rd_step` changes in cycle t → `bank_sel` is flipped in cycle t+1, and reads issued in t+1 use the new read bank.
- The engine must leave ≥LAT cycles between its last `wren` of a layer and the first read of that data. Forwarding covers only the exact commit cycle.

## Structure
- Package `dnn_buf_pkg` holds:
  - default values of `Ba`, `Bm`, `LAT`;
  - named bank-select constants BANK0_RD = 0 and BANK1_RD = 1;
  - the delay-line entry record {valid, bank, addr}.
- Sub-module `wr_delay_line`: a LAT-deep shift register of entries with an `any_valid` output that drives `pending`. The top level holds the two bank arrays, `step_q`/`bank_sel`, the read registers and the forwarding muxes.

## Test plan
- Reset check: drive `rst` = 0 for 100 ns with `clk` at a 100 ns period → `bank_sel` = 0, `pending` = 0, `rd_data` = 0, `host_rdata` = 0.
- Host load and read: `host_we` with `host_addr` = 5, `host_wdata` = 0x3C; next cycle `source_addr` = 5 → `rd_data` = 0x3C one cycle later; `host_rdata` for address 5 = 0x3C.
- Layer write and swap:
  - `wren` at t with `dest_addr` = 9, `wr_data` = 0xA5 at t+2 → `pending` high during t+1..t+2.
  - Then `rd_step` 0→1 → `bank_sel` = 1, and `source_addr` = 9 returns 0xA5.
- Swap with a write in flight:
  - `wren` at t with `dest_addr` = 12; `rd_step` changes at t+1; `wr_data` = 0x77 at t+2.
  - → the write commits to bank1, now the read bank.
  - A read of address 12 issued in t+2 returns 0x77 via forwarding.
- Collision: a host write of 0x11 and a datapath commit of 0x22 to the same bank and address on the same edge → the word reads back 0x22.
- Reset mid-flight:
  - Address 20 holds 0x55; `wren` to `dest_addr` = 20, then `rst` = 0 at t+1.
  - → after release, address 20 still reads 0x55, `pending` = 0 and `bank_sel` = 0.

Source files
------------

// File: rtl/act_pingpong_buf_pkg.sv
// dnn_buf_pkg: shared sizes, bank-select constants and write delay-line entry type
package dnn_buf_pkg;
    localparam int DEF_BA  = 8;
    localparam int DEF_BM  = 6;
    localparam int DEF_LAT = 2;
    localparam logic BANK0_RD = 1'b0;
    localparam logic BANK1_RD = 1'b1;
    typedef struct packed {
        logic              valid;
        logic              bank;
        logic [DEF_BM-1:0] addr;
    } wr_entry_t;
endpackage

// File: rtl/act_pingpong_buf_if.sv
// act_pingpong_buf_if: engine/host bus into the ping-pong activation buffer
// master drives step/address/write/host signals; slave returns read data, bank_sel, pending
interface act_pingpong_buf_if
    import dnn_buf_pkg::*;
#(
    parameter int Ba = DEF_BA,
    parameter int Bm = DEF_BM
);
    logic [Ba-1:0] rd_step;
    logic [Ba-1:0] wr_step;
    logic [Bm-1:0] source_addr;
    logic [Bm-1:0] dest_addr;
    logic          wren;
    logic [Ba-1:0] wr_data;
    logic          host_we;
    logic [Bm-1:0] host_addr;
    logic [Ba-1:0] host_wdata;
    logic [Ba-1:0] rd_data;
    logic [Ba-1:0] host_rdata;
    logic          bank_sel;
    logic          pending;
    modport master (
        output rd_step, wr_step, source_addr, dest_addr, wren, wr_data,
               host_we, host_addr, host_wdata,
        input  rd_data, host_rdata, bank_sel, pending
    );
    modport slave (
        input  rd_step, wr_step, source_addr, dest_addr, wren, wr_data,
               host_we, host_addr, host_wdata,
        output rd_data, host_rdata, bank_sel, pending
    );
endinterface

// File: rtl/act_pingpong_buf_wr_delay_line.sv
// wr_delay_line: LAT-deep shift register of pending write entries
// in_entry enters every cycle, out_entry is the entry committing this cycle,
// any_valid is high while any stage holds a live write
module wr_delay_line
    import dnn_buf_pkg::*;
#(
    parameter int LAT = DEF_LAT
) (
    input  logic      clk,
    input  logic      rst,
    input  wr_entry_t in_entry,
    output wr_entry_t out_entry,
    output logic      any_valid
);
    wr_entry_t line [LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) line[i] <= '0;
        end else begin
            line[0] <= in_entry;
            for (int i = 1; i < LAT; i++) line[i] <= line[i-1];
        end
    end

    assign out_entry = line[LAT-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < LAT; i++) any_valid = any_valid | line[i].valid;
    end
endmodule

// File: rtl/act_pingpong_buf.sv
// act_pingpong_buf: dual-bank activation buffer, one bank read while the other collects results
// clk/rst (async active-low) plain ports; bus (slave) carries engine steps/addresses,
// delayed layer writes, host load/readback, and returns rd_data, host_rdata, bank_sel, pending
module act_pingpong_buf
    import dnn_buf_pkg::*;
#(
    parameter int Ba  = DEF_BA,
    parameter int Bm  = DEF_BM,
    parameter int LAT = DEF_LAT
) (
    input logic               clk,
    input logic               rst,
    act_pingpong_buf_if.slave bus
);
    logic [Ba-1:0] bank0 [2**Bm];
    logic [Ba-1:0] bank1 [2**Bm];
    logic [Ba-1:0] step_q;
    logic          bank_sel;
    logic [Ba-1:0] rd_data;
    logic [Ba-1:0] host_rdata;
    wr_entry_t     in_entry;
    wr_entry_t     out_entry;
    logic          pending;
    logic          commit_rd_bank;
    logic          fwd_src;
    logic          fwd_host;
    logic          host_we_eff;
    logic          unused_ok;

    assign unused_ok = ^bus.wr_step;

    // Target bank is frozen at issue so a later swap cannot redirect the write
    assign in_entry = '{valid: bus.wren, bank: ~bank_sel, addr: bus.dest_addr};

    wr_delay_line #(.LAT(LAT)) u_dly (
        .clk      (clk),
        .rst      (rst),
        .in_entry (in_entry),
        .out_entry(out_entry),
        .any_valid(pending)
    );

    // A commit lands in the current read bank only when a swap happened while it was in flight
    assign commit_rd_bank = out_entry.valid && (out_entry.bank == bank_sel);
    assign fwd_src        = commit_rd_bank && (out_entry.addr == bus.source_addr);
    assign fwd_host       = commit_rd_bank && (out_entry.addr == bus.host_addr);
    // Datapath commit wins a same-address collision; the host write is dropped
    assign host_we_eff    = bus.host_we && !fwd_host;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q     <= '0;
            bank_sel   <= BANK0_RD;
            rd_data    <= '0;
            host_rdata <= '0;
        end else begin
            step_q     <= bus.rd_step;
            bank_sel   <= (bus.rd_step != step_q) ? ~bank_sel : bank_sel;
            rd_data    <= fwd_src ? bus.wr_data
                        : (bank_sel == BANK1_RD) ? bank1[bus.source_addr] : bank0[bus.source_addr];
            host_rdata <= fwd_host ? bus.wr_data
                        : (bank_sel == BANK1_RD) ? bank1[bus.host_addr] : bank0[bus.host_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (out_entry.valid && out_entry.bank == 1'b0) bank0[out_entry.addr] <= bus.wr_data;
        if (host_we_eff && bank_sel == BANK0_RD) bank0[bus.host_addr] <= bus.host_wdata;
    end

    always_ff @(posedge clk) begin
        if (out_entry.valid && out_entry.bank == 1'b1) bank1[out_entry.addr] <= bus.wr_data;
        if (host_we_eff && bank_sel == BANK1_RD) bank1[bus.host_addr] <= bus.host_wdata;
    end

    assign bus.rd_data    = rd_data;
    assign bus.host_rdata = host_rdata;
    assign bus.bank_sel   = bank_sel;
    assign bus.pending    = pending;
endmodule

// File: tb/tb_act_pingpong_buf.sv
// tb_act_pingpong_buf: directed self-checking bench for act_pingpong_buf
module tb_act_pingpong_buf;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    act_pingpong_buf_if bus ();

    act_pingpong_buf dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.rd_step = '0; bus.wr_step = '0; bus.source_addr = '0; bus.dest_addr = '0;
        bus.wren = 1'b0; bus.wr_data = '0; bus.host_we = 1'b0; bus.host_addr = '0;
        bus.host_wdata = '0;
        #100;
        chk("reset_bank_sel", {7'd0, bus.bank_sel}, 8'h00);
        chk("reset_pending", {7'd0, bus.pending}, 8'h00);
        chk("reset_rd_data", bus.rd_data, 8'h00);
        chk("reset_host_rdata", bus.host_rdata, 8'h00);
        #20 rst = 1'b1;
        step();
    endtask

    task automatic test_host_load();
        bus.host_we = 1'b1; bus.host_addr = 6'd5; bus.host_wdata = 8'h3C;
        step();
        bus.host_we = 1'b0; bus.source_addr = 6'd5;
        step();
        chk("host_load_rd_data", bus.rd_data, 8'h3C);
        chk("host_load_host_rdata", bus.host_rdata, 8'h3C);
    endtask

    task automatic test_layer_write_swap();
        bus.wren = 1'b1; bus.dest_addr = 6'd9;
        step();
        bus.wren = 1'b0;
        chk("layer_pending_t1", {7'd0, bus.pending}, 8'h01);
        step();
        chk("layer_pending_t2", {7'd0, bus.pending}, 8'h01);
        bus.wr_data = 8'hA5;
        step();
        bus.wr_data = 8'h00;
        chk("layer_pending_t3", {7'd0, bus.pending}, 8'h00);
        bus.rd_step = 8'd1;
        step();
        chk("layer_bank_sel", {7'd0, bus.bank_sel}, 8'h01);
        bus.source_addr = 6'd9;
        step();
        chk("layer_rd_data", bus.rd_data, 8'hA5);
        chk("layer_held_step", {7'd0, bus.bank_sel}, 8'h01);
    endtask

    task automatic apply_reset();
        bus.rd_step = 8'd0;
        rst = 1'b0;
        step();
        #20 rst = 1'b1;
        step();
    endtask

    task automatic test_swap_in_flight();
        apply_reset();
        bus.wren = 1'b1; bus.dest_addr = 6'd12;
        step();
        bus.wren = 1'b0; bus.rd_step = 8'd1;
        step();
        chk("inflight_bank_sel", {7'd0, bus.bank_sel}, 8'h01);
        bus.wr_data = 8'h77; bus.source_addr = 6'd12; bus.host_addr = 6'd12;
        step();
        bus.wr_data = 8'h00;
        chk("inflight_fwd_rd", bus.rd_data, 8'h77);
        chk("inflight_fwd_host", bus.host_rdata, 8'h77);
        step();
        chk("inflight_mem_rd", bus.rd_data, 8'h77);
    endtask

    task automatic test_collision();
        bus.wren = 1'b1; bus.dest_addr = 6'd30;
        step();
        bus.wren = 1'b0; bus.rd_step = 8'd0;
        step();
        bus.host_we = 1'b1; bus.host_addr = 6'd30; bus.host_wdata = 8'h11; bus.wr_data = 8'h22;
        step();
        bus.host_we = 1'b0; bus.wr_data = 8'h00; bus.source_addr = 6'd30;
        chk("collision_host_fwd", bus.host_rdata, 8'h22);
        step();
        chk("collision_mem", bus.rd_data, 8'h22);
        chk("collision_bank_sel", {7'd0, bus.bank_sel}, 8'h00);
    endtask

    task automatic test_reset_mid_flight();
        bus.host_we = 1'b1; bus.host_addr = 6'd20; bus.host_wdata = 8'h55;
        step();
        bus.host_we = 1'b0; bus.rd_step = 8'd1;
        step();
        bus.wren = 1'b1; bus.dest_addr = 6'd20; bus.wr_data = 8'hEE;
        step();
        bus.wren = 1'b0;
        chk("midrst_pending_before", {7'd0, bus.pending}, 8'h01);
        rst = 1'b0; bus.rd_step = 8'd0;
        @(posedge clk);
        #20 rst = 1'b1;
        chk("midrst_pending", {7'd0, bus.pending}, 8'h00);
        chk("midrst_bank_sel", {7'd0, bus.bank_sel}, 8'h00);
        bus.source_addr = 6'd20;
        repeat (3) step();
        bus.wr_data = 8'h00;
        chk("midrst_addr20", bus.rd_data, 8'h55);
        chk("midrst_pending_after", {7'd0, bus.pending}, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3] = '{8'hA0, 8'hA1, 8'hA2};
        for (int i = 0; i < 3; i++) begin
            bus.wren = 1'b1; bus.dest_addr = 6'(40 + i);
            bus.wr_data = (i == 2) ? vals[0] : 8'h00;
            step();
        end
        bus.wren = 1'b0; bus.wr_data = vals[1];
        step();
        bus.wr_data = vals[2];
        chk("b2b_pending_last", {7'd0, bus.pending}, 8'h01);
        step();
        bus.wr_data = 8'h00;
        chk("b2b_pending_done", {7'd0, bus.pending}, 8'h00);
        bus.rd_step = 8'd1;
        step();
        chk("b2b_bank_sel", {7'd0, bus.bank_sel}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            bus.source_addr = 6'(40 + i);
            step();
            chk($sformatf("b2b_rd_%0d", i), bus.rd_data, vals[i]);
        end
    endtask

    initial begin
        test_reset();
        test_host_load();
        test_layer_write_swap();
        test_swap_in_flight();
        test_collision();
        test_reset_mid_flight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
